hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core.
- Decides every cycle whether the PC and the IF/ID register hold, and whether ID/EX is cleared to a bubble.
- Detects load-use hazards and branch-operand hazards for operands read in D.
- Runs the multi-cycle mult/div busy sequencer and keeps a stall-cycle performance counter.
- Sits between the decode/execute control signals and the hold/clear inputs of the PC, IF/ID and ID/EX registers.

---
 rtl/hazard_stall_ctrl.sv | 100 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hold/bubble control for the 5-stage core: load-use and D-stage branch
// operand hazards, mult/div busy sequencing and a running stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_D,
  input  logic [4:0]       rt_D,
  input  logic             use_rs_D,
  input  logic             use_rt_D,
  input  logic             branch_D,
  input  logic             md_use_D,
  input  logic [4:0]       wa_E,
  input  logic             regwrite_E,
  input  logic             memread_E,
  input  logic [4:0]       wa_M,
  input  logic             memread_M,
  input  logic             md_start_E,
  input  logic             md_op_E,
  output logic             stall_pc,
  output logic             stall_F,
  output logic             flush_E,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt,
  output logic [31:0]      stall_count
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, lat;
  logic             match_E, match_M, lu, br, md, stall;

  // Hazard detection: same-cycle, register 0 never forwards a dependency
  always_comb begin
    match_E = (wa_E != 5'd0) &
              ((use_rs_D & (rs_D == wa_E)) | (use_rt_D & (rt_D == wa_E)));
    match_M = (wa_M != 5'd0) &
              ((use_rs_D & (rs_D == wa_M)) | (use_rt_D & (rt_D == wa_M)));
    lu      = memread_E & match_E;
    br      = branch_D & ((regwrite_E & match_E) | (memread_M & match_M));
    md      = md_use_D & (md_busy | md_start_E);
    stall   = (lu | br | md) & ~rst;
  end

  assign stall_pc = stall;
  assign stall_F  = stall;
  assign flush_E  = stall;
  assign md_busy  = (state == BUSY);
  assign md_cnt   = cnt;

  // Mult/div sequencer: a start in either state (re)loads the full latency
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lat      = md_op_E ? DIV_LAT : MULT_LAT;
    case (state)
      IDLE: begin
        if (md_start_E) begin
          state_nx = BUSY;
          cnt_nx   = lat;
        end
      end
      BUSY: begin
        if (md_start_E) begin
          cnt_nx = lat;
        end else if (cnt == CNT_ONE) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      stall_count <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (stall) stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scenario bench for hazard_stall_ctrl: each row of a scenario drives one cycle and
// queues the cycle's expected outputs, which are popped and compared mid-cycle.
module tb_hazard_stall_ctrl;

  logic        clk, rst;
  logic [4:0]  rs_D, rt_D, wa_E, wa_M;
  logic        use_rs_D, use_rt_D, branch_D, md_use_D;
  logic        regwrite_E, memread_E, memread_M, md_start_E, md_op_E;
  logic        stall_pc, stall_F, flush_E, md_busy;
  logic [3:0]  md_cnt;
  logic [31:0] stall_count;

  hazard_stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .rs_D(rs_D), .rt_D(rt_D), .use_rs_D(use_rs_D),
    .use_rt_D(use_rt_D), .branch_D(branch_D), .md_use_D(md_use_D), .wa_E(wa_E),
    .regwrite_E(regwrite_E), .memread_E(memread_E), .wa_M(wa_M),
    .memread_M(memread_M), .md_start_E(md_start_E), .md_op_E(md_op_E),
    .stall_pc(stall_pc), .stall_F(stall_F), .flush_E(flush_E), .md_busy(md_busy),
    .md_cnt(md_cnt), .stall_count(stall_count)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       branch;
    logic       md_use;
    logic [4:0] wa_E;
    logic       regwrite_E;
    logic       memread_E;
    logic [4:0] wa_M;
    logic       memread_M;
    logic       md_start;
    logic       md_op;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        stall;
    logic        busy;
    logic [3:0]  cnt;
    logic [31:0] count;
    string       name;
  } row_t;

  localparam stim_t IDLE_S = '0;

  row_t rows[$];
  row_t sb[$];
  row_t e, r;
  int   n_chk  = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input stim_t s);
    rst        = s.rst;
    rs_D       = s.rs;
    rt_D       = s.rt;
    use_rs_D   = s.use_rs;
    use_rt_D   = s.use_rt;
    branch_D   = s.branch;
    md_use_D   = s.md_use;
    wa_E       = s.wa_E;
    regwrite_E = s.regwrite_E;
    memread_E  = s.memread_E;
    wa_M       = s.wa_M;
    memread_M  = s.memread_M;
    md_start_E = s.md_start;
    md_op_E    = s.md_op;
  endtask

  function automatic void push_row(input stim_t s, input logic st, input logic bz,
                                   input logic [3:0] c, input logic [31:0] cnt,
                                   input string nm);
    row_t x;
    x.s = s; x.stall = st; x.busy = bz; x.cnt = c; x.count = cnt; x.name = nm;
    rows.push_back(x);
  endfunction

  task automatic do_reset();
    stim_t s;
    s = IDLE_S;
    s.rst = 1'b1;
    @(negedge clk);
    apply(s);
  endtask

  task automatic test_reset();
    stim_t s;
    s = '{rst:1'b1, rs:5'd8, use_rs:1'b1, memread_E:1'b1, regwrite_E:1'b1, wa_E:5'd8,
          branch:1'b1, md_use:1'b1, md_start:1'b1, default:'0};
    @(negedge clk);
    apply(s);
    push_row(s, 0, 0, 4'd0, 32'd0, "reset_hazard_gated");
    push_row(IDLE_S, 0, 0, 4'd0, 32'd0, "reset_release");
    while (rows.size() != 0) begin
      r = rows.pop_front();
      @(negedge clk);
      apply(r.s);
      sb.push_back(r);
      #2;
      e = sb.pop_front();
      n_chk++;
      if ({stall_pc, stall_F, flush_E, md_busy, md_cnt, stall_count} !==
          {e.stall, e.stall, e.stall, e.busy, e.cnt, e.count}) begin
        n_fail++;
        $display("FAIL %s: got stall=%b%b%b busy=%b cnt=%0d count=%0d, required stall=%b busy=%b cnt=%0d count=%0d",
                 e.name, stall_pc, stall_F, flush_E, md_busy, md_cnt, stall_count,
                 e.stall, e.busy, e.cnt, e.count);
      end
    end
  endtask

  task automatic test_load_use();
    do_reset();
    push_row('{rs:5'd8, use_rs:1'b1, memread_E:1'b1, regwrite_E:1'b1, wa_E:5'd8, default:'0},
             1, 0, 4'd0, 32'd0, "lu_rs_stall");
    push_row('{rs:5'd8, use_rs:1'b1, memread_M:1'b1, wa_M:5'd8, default:'0},
             0, 0, 4'd0, 32'd1, "lu_load_in_M");
    push_row('{rs:5'd6, rt:5'd5, use_rt:1'b1, memread_E:1'b1, regwrite_E:1'b1, wa_E:5'd5, default:'0},
             1, 0, 4'd0, 32'd1, "lu_rt_stall");
    push_row('{rs:5'd6, rt:5'd5, use_rs:1'b1, memread_E:1'b1, regwrite_E:1'b1, wa_E:5'd5, default:'0},
             0, 0, 4'd0, 32'd2, "lu_rt_unused");
    push_row(IDLE_S, 0, 0, 4'd0, 32'd2, "lu_idle");
    while (rows.size() != 0) begin
      r = rows.pop_front();
      @(negedge clk);
      apply(r.s);
      sb.push_back(r);
      #2;
      e = sb.pop_front();
      n_chk++;
      if ({stall_pc, stall_F, flush_E, md_busy, md_cnt, stall_count} !==
          {e.stall, e.stall, e.stall, e.busy, e.cnt, e.count}) begin
        n_fail++;
        $display("FAIL %s: got stall=%b%b%b busy=%b cnt=%0d count=%0d, required stall=%b busy=%b cnt=%0d count=%0d",
                 e.name, stall_pc, stall_F, flush_E, md_busy, md_cnt, stall_count,
                 e.stall, e.busy, e.cnt, e.count);
      end
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    push_row('{rs:5'd0, use_rs:1'b1, memread_E:1'b1, regwrite_E:1'b1, wa_E:5'd0, default:'0},
             0, 0, 4'd0, 32'd0, "zero_load_use");
    push_row('{rt:5'd0, use_rt:1'b1, branch:1'b1, regwrite_E:1'b1, wa_E:5'd0, default:'0},
             0, 0, 4'd0, 32'd0, "zero_branch_E");
    push_row('{rs:5'd0, use_rs:1'b1, branch:1'b1, memread_M:1'b1, wa_M:5'd0, default:'0},
             0, 0, 4'd0, 32'd0, "zero_branch_M");
    while (rows.size() != 0) begin
      r = rows.pop_front();
      @(negedge clk);
      apply(r.s);
      sb.push_back(r);
      #2;
      e = sb.pop_front();
      n_chk++;
      if ({stall_pc, stall_F, flush_E, md_busy, md_cnt, stall_count} !==
          {e.stall, e.stall, e.stall, e.busy, e.cnt, e.count}) begin
        n_fail++;
        $display("FAIL %s: got stall=%b%b%b busy=%b cnt=%0d count=%0d, required stall=%b busy=%b cnt=%0d count=%0d",
                 e.name, stall_pc, stall_F, flush_E, md_busy, md_cnt, stall_count,
                 e.stall, e.busy, e.cnt, e.count);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    push_row('{rs:5'd9, use_rs:1'b1, regwrite_E:1'b1, wa_E:5'd9, default:'0},
             0, 0, 4'd0, 32'd0, "alu_no_branch");
    push_row('{rs:5'd9, use_rs:1'b1, branch:1'b1, regwrite_E:1'b1, wa_E:5'd9, default:'0},
             1, 0, 4'd0, 32'd0, "beq_addi_in_E");
    push_row('{rs:5'd9, use_rs:1'b1, branch:1'b1, wa_M:5'd9, default:'0},
             0, 0, 4'd0, 32'd1, "beq_addi_in_M");
    push_row('{rs:5'd9, use_rs:1'b1, branch:1'b1, memread_E:1'b1, regwrite_E:1'b1, wa_E:5'd9, default:'0},
             1, 0, 4'd0, 32'd1, "beq_lw_in_E");
    push_row('{rs:5'd9, use_rs:1'b1, branch:1'b1, memread_M:1'b1, wa_M:5'd9, default:'0},
             1, 0, 4'd0, 32'd2, "beq_lw_in_M");
    push_row('{rs:5'd9, use_rs:1'b1, branch:1'b1, default:'0},
             0, 0, 4'd0, 32'd3, "beq_lw_in_W");
    push_row(IDLE_S, 0, 0, 4'd0, 32'd3, "beq_idle");
    while (rows.size() != 0) begin
      r = rows.pop_front();
      @(negedge clk);
      apply(r.s);
      sb.push_back(r);
      #2;
      e = sb.pop_front();
      n_chk++;
      if ({stall_pc, stall_F, flush_E, md_busy, md_cnt, stall_count} !==
          {e.stall, e.stall, e.stall, e.busy, e.cnt, e.count}) begin
        n_fail++;
        $display("FAIL %s: got stall=%b%b%b busy=%b cnt=%0d count=%0d, required stall=%b busy=%b cnt=%0d count=%0d",
                 e.name, stall_pc, stall_F, flush_E, md_busy, md_cnt, stall_count,
                 e.stall, e.busy, e.cnt, e.count);
      end
    end
  endtask

  task automatic test_div();
    stim_t mflo;
    do_reset();
    mflo = IDLE_S;
    mflo.md_use = 1'b1;
    push_row('{md_use:1'b1, md_start:1'b1, md_op:1'b1, default:'0},
             1, 0, 4'd0, 32'd0, "div_start_cycle");
    for (int k = 1; k <= 10; k++)
      push_row(mflo, 1, 1, 4'(11 - k), 32'(k), "div_busy");
    push_row(mflo, 0, 0, 4'd0, 32'd11, "div_done");
    while (rows.size() != 0) begin
      r = rows.pop_front();
      @(negedge clk);
      apply(r.s);
      sb.push_back(r);
      #2;
      e = sb.pop_front();
      n_chk++;
      if ({stall_pc, stall_F, flush_E, md_busy, md_cnt, stall_count} !==
          {e.stall, e.stall, e.stall, e.busy, e.cnt, e.count}) begin
        n_fail++;
        $display("FAIL %s: got stall=%b%b%b busy=%b cnt=%0d count=%0d, required stall=%b busy=%b cnt=%0d count=%0d",
                 e.name, stall_pc, stall_F, flush_E, md_busy, md_cnt, stall_count,
                 e.stall, e.busy, e.cnt, e.count);
      end
    end
  endtask

  task automatic test_mult_restart();
    stim_t mstart;
    do_reset();
    mstart = IDLE_S;
    mstart.md_start = 1'b1;
    push_row(mstart, 0, 0, 4'd0, 32'd0, "mult_start");
    push_row(IDLE_S, 0, 1, 4'd5, 32'd0, "mult_busy1");
    push_row(mstart, 0, 1, 4'd4, 32'd0, "mult_restart");
    for (int k = 5; k >= 1; k--)
      push_row(IDLE_S, 0, 1, 4'(k), 32'd0, "mult_reloaded");
    push_row(IDLE_S, 0, 0, 4'd0, 32'd0, "mult_done");
    while (rows.size() != 0) begin
      r = rows.pop_front();
      @(negedge clk);
      apply(r.s);
      sb.push_back(r);
      #2;
      e = sb.pop_front();
      n_chk++;
      if ({stall_pc, stall_F, flush_E, md_busy, md_cnt, stall_count} !==
          {e.stall, e.stall, e.stall, e.busy, e.cnt, e.count}) begin
        n_fail++;
        $display("FAIL %s: got stall=%b%b%b busy=%b cnt=%0d count=%0d, required stall=%b busy=%b cnt=%0d count=%0d",
                 e.name, stall_pc, stall_F, flush_E, md_busy, md_cnt, stall_count,
                 e.stall, e.busy, e.cnt, e.count);
      end
    end
  endtask

  task automatic test_reset_busy();
    stim_t mflo, rst_s;
    do_reset();
    mflo = IDLE_S;
    mflo.md_use = 1'b1;
    rst_s = '{rst:1'b1, md_use:1'b1, rs:5'd8, use_rs:1'b1, memread_E:1'b1, wa_E:5'd8, default:'0};
    push_row('{md_use:1'b1, md_start:1'b1, md_op:1'b1, default:'0},
             1, 0, 4'd0, 32'd0, "rb_div_start");
    for (int k = 1; k <= 4; k++)
      push_row(mflo, 1, 1, 4'(11 - k), 32'(k), "rb_busy");
    push_row(rst_s, 0, 1, 4'd6, 32'd5, "rb_reset_cycle");
    push_row(mflo, 0, 0, 4'd0, 32'd0, "rb_after_reset");
    while (rows.size() != 0) begin
      r = rows.pop_front();
      @(negedge clk);
      apply(r.s);
      sb.push_back(r);
      #2;
      e = sb.pop_front();
      n_chk++;
      if ({stall_pc, stall_F, flush_E, md_busy, md_cnt, stall_count} !==
          {e.stall, e.stall, e.stall, e.busy, e.cnt, e.count}) begin
        n_fail++;
        $display("FAIL %s: got stall=%b%b%b busy=%b cnt=%0d count=%0d, required stall=%b busy=%b cnt=%0d count=%0d",
                 e.name, stall_pc, stall_F, flush_E, md_busy, md_cnt, stall_count,
                 e.stall, e.busy, e.cnt, e.count);
      end
    end
  endtask

  initial begin
    apply(IDLE_S);
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_div();
    test_mult_restart();
    test_reset_busy();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule
